// File: rtl/note_sequencer.sv
// Note recorder/player: stores up to 2^DEPTH_LOG2 note codes, then plays them back
// on a BEAT_CYCLES note / GAP_CYCLES silence grid. Define LOOP_EN for endless playback.
module note_sequencer #(
  parameter int NOTE_W      = 4,
  parameter int DEPTH_LOG2  = 4,
  parameter int BEAT_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rec_req_i,
  input  logic [NOTE_W-1:0]     note_in_i,
  input  logic                  play_req_i,
  input  logic                  stop_req_i,
  input  logic                  clear_req_i,
  output logic [NOTE_W-1:0]     note_out_o,
  output logic                  note_valid_o,
  output logic                  busy_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2-1:0] play_idx_o,
  output logic                  done_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int MAXC  = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [CNT_W-1:0]    BEAT_LD  = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GAP_LD   = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [NOTE_W-1:0]     note_q, note_d;
  logic                  done_q, done_d;

  logic [NOTE_W-1:0]     mem_q [DEPTH];
  logic                  mem_we;
  logic                  slot_end;
  logic                  last_slot;
  logic                  full;

  assign full      = (count_q == CNT_FULL);
  assign last_slot = ({1'b0, idx_q} == (count_q - CNT_ONE));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    idx_d    = idx_q;
    note_d   = note_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    slot_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Highest-priority request wins; the rest of the cycle's requests are dropped.
        if (stop_req_i) begin
          state_d = S_IDLE;
        end else if (clear_req_i) begin
          count_d = '0;
        end else if (play_req_i) begin
          if (count_q != '0) begin
            state_d = S_PLAY;
            idx_d   = '0;
            note_d  = mem_q[0];
            cnt_d   = BEAT_LD;
          end
        end else if (rec_req_i && !full) begin
          mem_we  = 1'b1;
          count_d = count_q + CNT_ONE;
        end
      end
      S_PLAY: begin
        if (stop_req_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_CYCLES != 0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else begin
          slot_end = 1'b1;
        end
      end
      S_GAP: begin
        if (stop_req_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          slot_end = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (slot_end) begin
      if (!last_slot) begin
        state_d = S_PLAY;
        idx_d   = idx_q + DEPTH_LOG2'(1);
        note_d  = mem_q[idx_q + DEPTH_LOG2'(1)];
        cnt_d   = BEAT_LD;
      end else begin
`ifdef LOOP_EN
        state_d = S_PLAY;
        idx_d   = '0;
        note_d  = mem_q[0];
        cnt_d   = BEAT_LD;
`else
        state_d = S_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      note_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      done_q  <= done_d;
    end
  end

  // Note storage is deliberately left out of reset; count_q alone defines what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[DEPTH_LOG2-1:0]] <= note_in_i;
  end

  assign note_out_o   = note_q;
  assign note_valid_o = (state_q == S_PLAY);
  assign busy_o       = (state_q != S_IDLE);
  assign count_o      = count_q;
  assign full_o       = full;
  assign play_idx_o   = idx_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: timeline-based reference model plus directed
// literal checks and a randomized request phase.
module tb_note_sequencer;
  localparam int NW = 4, DL = 4, BEAT = 4, GAP = 2, PER = BEAT + GAP, DEPTH = 16;

  logic clk = 1'b0, rst_n = 1'b1;
  logic rec = 1'b0, play = 1'b0, stop = 1'b0, clr = 1'b0;
  logic [NW-1:0] nin = '0;
  logic [NW-1:0] nout;
  logic nv, busy, full, done;
  logic [DL:0] cnt;
  logic [DL-1:0] pidx;

  always #5 clk = ~clk;

  note_sequencer #(.NOTE_W(NW), .DEPTH_LOG2(DL), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .rec_req_i(rec), .note_in_i(nin), .play_req_i(play),
    .stop_req_i(stop), .clear_req_i(clr), .note_out_o(nout), .note_valid_o(nv),
    .busy_o(busy), .count_o(cnt), .full_o(full), .play_idx_o(pidx), .done_o(done));

  int total = 0, bad = 0;
  bit chk_en = 0;

  // Reference: recorded list plus elapsed time since play start; outputs follow from t.
  logic [NW-1:0] m [DEPTH];
  int mcnt = 0, mt = 0, midx = 0;
  bit mplay = 0, mdone = 0;
  logic [NW-1:0] mnote = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt = 0; mplay = 0; mt = 0; mnote = '0; midx = 0; mdone = 0;
    end else begin
      mdone = 0;
      if (mplay) begin
        if (stop) mplay = 0;
        else begin
          mt++;
          if (mt == mcnt * PER) begin
`ifdef LOOP_EN
            mt = 0;
`else
            mplay = 0; mdone = 1;
`endif
          end
        end
      end else if (!stop) begin
        if (clr) mcnt = 0;
        else if (play) begin
          if (mcnt != 0) begin mplay = 1; mt = 0; end
        end else if (rec && mcnt < DEPTH) begin
          m[mcnt] = nin; mcnt++;
        end
      end
      if (mplay) begin midx = mt / PER; mnote = m[midx]; end
    end
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("busy", int'(busy), int'(mplay));
      chk("note_valid", int'(nv), int'(mplay && (mt % PER) < BEAT));
      chk("note_out", int'(nout), int'(mnote));
      chk("play_idx", int'(pidx), midx);
      chk("count", int'(cnt), mcnt);
      chk("full", int'(full), int'(mcnt == DEPTH));
      chk("done", int'(done), int'(mdone));
    end
  end

  task automatic tick(int n); repeat (n) @(negedge clk); endtask
  task automatic do_rec(logic [NW-1:0] v); rec = 1; nin = v; @(negedge clk); rec = 0; endtask
  task automatic do_play(); play = 1; @(negedge clk); play = 0; endtask
  task automatic do_stop(); stop = 1; @(negedge clk); stop = 0; endtask
  task automatic do_clr(); clr = 1; @(negedge clk); clr = 0; endtask

  logic [NW-1:0] arr [17];

  initial begin
    #1 rst_n = 1'b0;
    tick(2);
    chk("rst_count", int'(cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(nv), 0);
    chk("rst_note", int'(nout), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    chk_en = 1;
    tick(1);

    // Three-note playback timeline.
    do_rec(4'd3); do_rec(4'd7); do_rec(4'd9);
    chk("t1_count", int'(cnt), 3);
    do_play();
    chk("t1_first_note", int'(nout), 3);
    chk("t1_first_valid", int'(nv), 1);
    chk("t1_busy", int'(busy), 1);
    tick(4);
    chk("t1_gap_valid", int'(nv), 0);
    chk("t1_gap_note", int'(nout), 3);
    tick(2);
    chk("t1_second_note", int'(nout), 7);
    tick(6);
    chk("t1_third_note", int'(nout), 9);
    tick(6);
`ifndef LOOP_EN
    chk("t1_done", int'(done), 1);
    chk("t1_busy_fall", int'(busy), 0);
    tick(1);
    chk("t1_done_pulse", int'(done), 0);
`else
    chk("t1_wrap_note", int'(nout), 3);
    chk("t1_wrap_busy", int'(busy), 1);
    do_stop();
    chk("t1_stop_busy", int'(busy), 0);
`endif

    // Fill to capacity; the 17th request is dropped.
    do_clr();
    for (int i = 0; i < 17; i++) begin
      arr[i] = NW'($urandom);
      do_rec(arr[i]);
    end
    chk("t2_count", int'(cnt), 16);
    chk("t2_full", int'(full), 1);
    do_play();
    tick(15 * PER);
    chk("t2_last_note", int'(nout), int'(arr[15]));
    chk("t2_last_idx", int'(pidx), 15);
    tick(PER);
    do_stop();

    // Empty play, and clear after records.
    do_clr();
    chk("t3_count0", int'(cnt), 0);
    do_play();
    chk("t3_empty_busy", int'(busy), 0);
    tick(3);
    chk("t3_empty_done", int'(done), 0);
    for (int i = 0; i < 5; i++) do_rec(NW'(i + 1));
    chk("t3_count5", int'(cnt), 5);
    do_clr();
    chk("t3_cleared", int'(cnt), 0);

    // Record ignored while busy; stop in the second note's gap.
    for (int i = 0; i < 4; i++) do_rec(NW'(i + 10));
    do_play();
    tick(2);
    do_rec(4'd5);
    chk("t4_rec_ignored", int'(cnt), 4);
    tick(7);
    chk("t4_in_gap_valid", int'(nv), 0);
    chk("t4_in_gap_busy", int'(busy), 1);
    do_stop();
    chk("t4_stop_busy", int'(busy), 0);
    chk("t4_stop_valid", int'(nv), 0);
    chk("t4_stop_done", int'(done), 0);
    tick(2);

    // Asynchronous reset mid-playback.
    do_play();
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(nv), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_count", int'(cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    do_play();
    chk("t5_play_after_rst", int'(busy), 0);

    // Randomized request traffic.
    for (int c = 0; c < 3000; c++) begin
      rec  = ($urandom_range(3) == 0);
      nin  = NW'($urandom);
      play = ($urandom_range(19) == 0);
      stop = ($urandom_range(149) == 0);
      clr  = ($urandom_range(99) == 0);
      @(negedge clk);
    end
    rec = 0; play = 0; stop = 0; clr = 0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Records up to 2^DEPTH_LOG2 note codes into an internal register file and plays them back in order on a fixed beat grid, with a silent gap after every note. It sits between the keypad/switch front end and the tone generator, and replaces ad-hoc load/playback sequencing with one scheduler. It owns the beat timebase, the record pointer, the playback pointer and the note-on/note-off framing.

## Interface

- NOTE_W, 4: width of a note code.
- DEPTH_LOG2, 4: log2 of note storage depth (16 entries).
- BEAT_CYCLES, 25000000: clk cycles a note sounds (0.5 s at 50 MHz); must be ≥1.
- GAP_CYCLES, 2500000: clk cycles of silence after each note; 0 disables the gap.

- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low; clears all control state.
- rec_req  in  1  one-cycle pulse: store note_in at next free slot.
- note_in  in  NOTE_W  note code sampled with rec_req.
- play_req  in  1  one-cycle pulse: start playback from slot 0.
- stop_req  in  1  abort playback.
- clear_req  in  1  discard all recorded notes.
- note_out  out  NOTE_W  note code for the tone generator.
- note_valid  out  1  high while a note sounds.
- busy  out  1  high in PLAY or GAP.
- count  out  DEPTH_LOG2+1  number of notes recorded.
- full  out  1  count == 2^DEPTH_LOG2.
- play_idx  out  DEPTH_LOG2  slot currently playing.
- done  out  1  one-cycle pulse on natural end of playback.

## Operation

- States: IDLE, PLAY, GAP. Reset → IDLE; count=0, play_idx=0, note_out=0, note_valid=0, busy=0, done=0, beat counter=0. Storage contents are not reset.
- Request priority within a cycle: stop_req > clear_req > play_req > rec_req. Lower-priority requests in the same cycle are dropped.
- IDLE:
  - rec_req with !full → mem[count]←note_in, count+1.
  - rec_req when full → ignored. count saturates at 2^DEPTH_LOG2.
  - clear_req → count=0.
  - play_req with count≠0 → PLAY, play_idx=0, note_out=mem[0], counter=BEAT_CYCLES-1.
  - play_req with count=0 → ignored, no done.
- PLAY: note_valid=1, counter decrements. At counter==0:
  - GAP_CYCLES≠0 → GAP, counter=GAP_CYCLES-1.
  - GAP_CYCLES=0 → end-of-slot action.
- GAP: note_valid=0, note_out holds, counter decrements. At counter==0 → end-of-slot action.
- End-of-slot action:
  - play_idx < count-1 → play_idx+1, note_out=mem[play_idx+1], PLAY, counter reload.
  - play_idx = count-1 → IDLE, done=1 for one cycle.
- rec_req and clear_req are ignored while busy.
- stop_req in PLAY or GAP → IDLE next cycle, note_valid=0, no done. stop_req in IDLE → no effect.
- busy = (state≠IDLE). full is derived combinationally from count.

## Timing

- play_req sampled at edge T → at T+1: busy=1, note_valid=1, note_out=mem[0].
- note_valid is high for exactly BEAT_CYCLES cycles per note, then low for exactly GAP_CYCLES cycles.
- Per-note period is BEAT_CYCLES+GAP_CYCLES. Total playback length is count×(BEAT_CYCLES+GAP_CYCLES) cycles.
- done is high in the first IDLE cycle after the last slot, coincident with busy falling.
- rec_req at edge T → count and full updated at T+1. A write to slot k is readable by a play_req issued at T+1.
- Reset assertion mid-playback → outputs go to reset values immediately (asynchronous). Operation resumes on the first clk edge after deassertion.

## Configuration

- LOOP_EN defined:
  - The end-of-slot action at play_idx = count-1 wraps to play_idx=0 and PLAY, and does not pulse done.
  - Playback runs until stop_req.
- LOOP_EN undefined: playback stops after the last slot with a done pulse, as described above.

## Test plan

Bench parameters: BEAT_CYCLES=4, GAP_CYCLES=2.

- Record 3,7,9, then play_req → note_valid high 4 cycles with note_out=3, low 2 cycles, then 7, then 9. done pulses one cycle 18 cycles after play start; busy falls in the same cycle.
- Issue 17 rec_req pulses → count=16, full=1. 17th note not stored. Playback emits 16 notes, last = 16th recorded value.
- play_req with count=0 → busy stays 0, no done. clear_req after 5 records → count=0.
- stop_req during the 2nd note's GAP → IDLE next cycle, note_valid=0, no done. rec_req issued during PLAY is ignored; count is unchanged.
- Assert reset during PLAY → note_valid, busy, count=0 immediately. The next play_req is ignored.
- LOOP_EN with 2 notes (1,2) → sequence 1,2,1,2… with no done. stop_req ends playback within one cycle.
